// File: rtl/distance_window_alarm.sv
// Multi-channel distance window monitor: per-channel hysteresis and debounce feed a
// blink/hold alarm FSM that drives an indicator LED.
module distance_window_alarm #(
    parameter int WIDTH        = 8,
    parameter int N_CH         = 4,
    parameter int LIM_LO       = 10,
    parameter int LIM_HI       = 20,
    parameter int HYST         = 2,
    parameter int DEBOUNCE     = 4,
    parameter int BLINK_HALF   = 25000000,
    parameter int ALARM_CYCLES = 250000000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   sample_valid,
    input  logic [N_CH*WIDTH-1:0]  distancia_cm,
    input  logic [N_CH-1:0]        ch_enable,
    input  logic                   ack,
    output logic [N_CH-1:0]        dentro_limite,
    output logic                   led,
    output logic                   alarm,
    output logic [1:0]             o_dbg_state
);

    localparam longint MAX_D  = (longint'(1) << WIDTH) - longint'(1);
    localparam longint LO_OUT = (LIM_LO > HYST) ? longint'(LIM_LO - HYST) : longint'(0);
    localparam longint HI_SUM = longint'(LIM_HI) + longint'(HYST);
    localparam longint HI_OUT = (HI_SUM > MAX_D) ? MAX_D : HI_SUM;

    localparam logic [WIDTH-1:0] LO_OUT_W = WIDTH'(LO_OUT);
    localparam logic [WIDTH-1:0] HI_OUT_W = WIDTH'(HI_OUT);
    localparam logic [WIDTH-1:0] LIM_LO_W = WIDTH'(LIM_LO);
    localparam logic [WIDTH-1:0] LIM_HI_W = WIDTH'(LIM_HI);

    localparam int CNT_W = (DEBOUNCE > 0) ? $clog2(DEBOUNCE + 1) : 1;
    localparam int TM_W  = (ALARM_CYCLES > 0) ? $clog2(ALARM_CYCLES + 1) : 1;
    localparam int PH_W  = (BLINK_HALF > 0) ? $clog2(BLINK_HALF + 1) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);
    localparam logic [TM_W-1:0]  TM_LOAD  = TM_W'(ALARM_CYCLES);
    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(BLINK_HALF - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BLINK = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    logic [N_CH-1:0] w_fall;
    logic            w_fall_any;
    logic            w_any_out;

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        logic [WIDTH-1:0] w_d;
        logic             w_differs;
        logic             r_in;
        logic             r_prev;
        logic [CNT_W-1:0] r_cnt;

        assign w_d = distancia_cm[k*WIDTH +: WIDTH];
        // The exit band is wider than the entry band, so a reading near an edge cannot chatter.
        assign w_differs = r_in ? ((w_d < LO_OUT_W) || (w_d > HI_OUT_W))
                                : ((w_d >= LIM_LO_W) && (w_d <= LIM_HI_W));

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_in   <= 1'b0;
                r_prev <= 1'b0;
                r_cnt  <= '0;
            end else begin
                r_prev <= r_in;
                if (sample_valid) begin
                    if (!w_differs) begin
                        r_cnt <= '0;
                    end else if (r_cnt == CNT_LAST) begin
                        r_in  <= ~r_in;
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
            end
        end

        assign dentro_limite[k] = r_in;
        assign w_fall[k]        = r_prev & ~r_in & ch_enable[k];
    end

    assign w_fall_any = |w_fall;
    assign w_any_out  = |(ch_enable & ~dentro_limite);

    state_t          r_state, w_state_nx;
    logic [TM_W-1:0] r_timer, w_timer_nx;
    logic [PH_W-1:0] r_phase, w_phase_nx;
    logic            r_led, w_led_nx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_timer <= '0;
            r_phase <= '0;
            r_led   <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_timer <= w_timer_nx;
            r_phase <= w_phase_nx;
            r_led   <= w_led_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_timer_nx = r_timer;
        w_phase_nx = r_phase;
        w_led_nx   = r_led;
        case (r_state)
            S_IDLE: begin
                w_led_nx = 1'b0;
                if (w_fall_any) begin
                    w_state_nx = S_BLINK;
                    w_timer_nx = TM_LOAD;
                    w_phase_nx = '0;
                    w_led_nx   = 1'b1;
                end
            end
            S_BLINK: begin
                if (r_phase >= PH_LAST) begin
                    w_phase_nx = '0;
                    w_led_nx   = ~r_led;
                end else begin
                    w_phase_nx = r_phase + PH_W'(1);
                end
                // A fresh fall extends the alarm without restarting the blink phase.
                if (w_fall_any) begin
                    w_timer_nx = TM_LOAD;
                end else if (r_timer <= TM_W'(1)) begin
                    w_state_nx = w_any_out ? S_HOLD : S_IDLE;
                    w_timer_nx = '0;
                    w_phase_nx = '0;
                    w_led_nx   = w_any_out;
                end else begin
                    w_timer_nx = r_timer - TM_W'(1);
                end
            end
            S_HOLD: begin
                w_led_nx = 1'b1;
                if (w_fall_any) begin
                    w_state_nx = S_BLINK;
                    w_timer_nx = TM_LOAD;
                    w_phase_nx = '0;
                end else if (ack || !w_any_out) begin
                    w_state_nx = S_IDLE;
                    w_led_nx   = 1'b0;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
                w_timer_nx = '0;
                w_phase_nx = '0;
                w_led_nx   = 1'b0;
            end
        endcase
    end

    assign led         = r_led;
    assign alarm       = (r_state != S_IDLE);
    assign o_dbg_state = r_state;

endmodule
